// File: rtl/up_down_sweep_ctrl_pkg.sv
// rtl/up_down_sweep_ctrl_pkg.sv - shared state encoding and default widths for the sweep sequencer
package up_down_sweep_ctrl_pkg;

    localparam int W_DEF  = 4;
    localparam int DW_DEF = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CLEAR    = 3'd1;
    localparam logic [2:0] ST_UP       = 3'd2;
    localparam logic [2:0] ST_DWELL_HI = 3'd3;
    localparam logic [2:0] ST_DOWN     = 3'd4;
    localparam logic [2:0] ST_DWELL_LO = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        CLEAR    = ST_CLEAR,
        UP       = ST_UP,
        DWELL_HI = ST_DWELL_HI,
        DOWN     = ST_DOWN,
        DWELL_LO = ST_DWELL_LO
    } state_t;

endpackage

// File: rtl/up_down_sweep_ctrl_if.sv
// rtl/up_down_sweep_ctrl_if.sv - control/counter signal bundle between sequencer and its environment
interface up_down_sweep_ctrl_if
    import up_down_sweep_ctrl_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int DW = DW_DEF
);
    logic          start;
    logic          stop;
    logic [W-1:0]  limit;
    logic [DW-1:0] dwell;
    logic [W-1:0]  cnt;
    logic          en;
    logic          down;
    logic          clr;
    logic          busy;
    logic          done;

    modport master (
        output start, stop, limit, dwell, cnt,
        input  en, down, clr, busy, done
    );

    modport slave (
        input  start, stop, limit, dwell, cnt,
        output en, down, clr, busy, done
    );

endinterface

// File: rtl/up_down_sweep_ctrl_dwell_timer.sv
// rtl/up_down_sweep_ctrl_dwell_timer.sv - loadable down-counter timing the hold at each sweep end
module dwell_timer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    output logic          expire
);

    logic [DW-1:0] tmr_q, tmr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    always_comb begin
        tmr_d = tmr_q;
        if (load) begin
            tmr_d = load_val;
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - DW'(1);
        end
    end

    // A load of N gives N cycles of hold; expire marks the last one.
    assign expire = (tmr_q == DW'(1));

endmodule

// File: rtl/up_down_sweep_ctrl.sv
// rtl/up_down_sweep_ctrl.sv - drives en/down/clr of an up/down counter through repeated 0..limit..0 sweeps
module up_down_sweep_ctrl
    import up_down_sweep_ctrl_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                 clk,
    input  logic                 res,
    up_down_sweep_ctrl_if.slave  bus
);

    state_t        state_q, state_d;
    logic          en_q, en_d;
    logic          down_q, down_d;
    logic          clr_q, clr_d;
    logic          done_q, done_d;
    logic          stop_q, stop_d;
    logic [W-1:0]  lim_q, lim_d;
    logic [DW-1:0] dwl_q, dwl_d;
    logic          tmr_load;
    logic          tmr_expire;
    logic [DW-1:0] hold_len;

    assign hold_len = (dwl_q == '0) ? DW'(1) : dwl_q;

    dwell_timer #(.DW(DW)) u_dwell_timer (
        .clk      (clk),
        .rst_n    (res),
        .load     (tmr_load),
        .load_val (hold_len),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            down_q  <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            stop_q  <= 1'b0;
            lim_q   <= '0;
            dwl_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            down_q  <= down_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            stop_q  <= stop_d;
            lim_q   <= lim_d;
            dwl_q   <= dwl_d;
        end
    end

    // Outputs are registered, so each transition sets the values seen in the first cycle of the next state.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        down_d   = down_q;
        clr_d    = 1'b0;
        done_d   = 1'b0;
        stop_d   = stop_q;
        lim_d    = lim_q;
        dwl_d    = dwl_q;
        tmr_load = 1'b0;

        case (state_q)
            IDLE: begin
                en_d   = 1'b0;
                down_d = 1'b0;
                if (bus.start) begin
                    state_d = CLEAR;
                    clr_d   = 1'b1;
                    lim_d   = bus.limit;
                    dwl_d   = bus.dwell;
                    stop_d  = 1'b0;
                end
            end
            CLEAR: begin
                if (lim_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = UP;
                    en_d    = 1'b1;
                    down_d  = 1'b0;
                end
            end
            UP: begin
                if (bus.cnt == lim_q - W'(1)) begin
                    state_d  = DWELL_HI;
                    en_d     = 1'b0;
                    down_d   = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            DWELL_HI: begin
                if (tmr_expire) begin
                    state_d = DOWN;
                    en_d    = 1'b1;
                    down_d  = 1'b1;
                end
            end
            DOWN: begin
                if (bus.cnt == W'(1)) begin
                    state_d  = DWELL_LO;
                    en_d     = 1'b0;
                    down_d   = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            DWELL_LO: begin
                if (tmr_expire) begin
                    if (stop_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = UP;
                        en_d    = 1'b1;
                        down_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                down_d  = 1'b0;
            end
        endcase

        if (state_q != IDLE && bus.stop) begin
            stop_d = 1'b1;
        end
    end

    assign bus.en   = en_q;
    assign bus.down = down_q;
    assign bus.clr  = clr_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_up_down_sweep_ctrl.sv
// tb/tb_up_down_sweep_ctrl.sv - sweep sequencer driving a behavioural up/down counter against a waveform model
module tb_up_down_sweep_ctrl;
    import up_down_sweep_ctrl_pkg::*;

    localparam int W  = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         chk_cnt;
        logic         en;
        logic         down;
        logic         clr;
        logic         busy;
        logic         done;
    } exp_t;

    logic         clk = 1'b0;
    logic         res = 1'b0;
    logic [W-1:0] cnt_r = '0;
    logic         prev_down;
    int           tests = 0;
    int           fails = 0;
    exp_t         q[$];

    up_down_sweep_ctrl_if #(.W(W), .DW(DW)) bus ();

    up_down_sweep_ctrl #(.W(W), .DW(DW)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #25 clk = ~clk;

    // Counter being sequenced: clear wins over enable; no reset of its own.
    always @(posedge clk) begin
        if (bus.clr)
            cnt_r <= '0;
        else if (bus.en)
            cnt_r <= bus.down ? cnt_r - W'(1) : cnt_r + W'(1);
    end
    assign bus.cnt = cnt_r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int c, input logic chk, input logic en, input logic dn,
                                input logic clr, input logic busy, input logic done);
        exp_t e;
        e.cnt = W'(c); e.chk_cnt = chk; e.en = en; e.down = dn;
        e.clr = clr; e.busy = busy; e.done = done;
        return e;
    endfunction

    // Expected per-cycle waveform from the cycle after start is accepted to the done cycle.
    task automatic build(input int L, input int D, input int nsw);
        int dd = (D == 0) ? 1 : D;
        q.delete();
        q.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        if (L == 0) begin
            q.push_back(mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            return;
        end
        for (int s = 0; s < nsw; s++) begin
            for (int k = 0; k < L; k++)  q.push_back(mk(k, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
            for (int k = 0; k < dd; k++) q.push_back(mk(L, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
            for (int k = L; k > 0; k--)  q.push_back(mk(k, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
            for (int k = 0; k < dd; k++) q.push_back(mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        q.push_back(mk(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic compare_cycle(input exp_t e, input int L, input int i);
        if (e.chk_cnt) check($sformatf("L%0d c%0d cnt", L, i), 32'(bus.cnt), 32'(e.cnt));
        check($sformatf("L%0d c%0d en",   L, i), 32'(bus.en),   32'(e.en));
        check($sformatf("L%0d c%0d down", L, i), 32'(bus.down), 32'(e.down));
        check($sformatf("L%0d c%0d clr",  L, i), 32'(bus.clr),  32'(e.clr));
        check($sformatf("L%0d c%0d busy", L, i), 32'(bus.busy), 32'(e.busy));
        check($sformatf("L%0d c%0d done", L, i), 32'(bus.done), 32'(e.done));
        if (bus.en) check($sformatf("L%0d c%0d dir_hold", L, i), 32'(bus.down), 32'(prev_down));
        prev_down = bus.down;
    endtask

    // Stop is pulsed in the first rising cycle of the last sweep; restart re-pulses start with limit 3 mid-sweep.
    task automatic run(input int L, input int D, input int nsw, input bit stop_with_start, input bit restart);
        int dd;
        int stop_idx;
        dd = (D == 0) ? 1 : D;
        build(L, D, nsw);
        stop_idx = (L == 0) ? -1 : 1 + (nsw - 1) * (2 * L + 2 * dd);
        bus.start = 1'b1;
        bus.limit = W'(L);
        bus.dwell = DW'(D);
        bus.stop  = stop_with_start;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        prev_down = 1'b0;
        foreach (q[i]) begin
            compare_cycle(q[i], L, i);
            bus.stop = (i == stop_idx);
            if (restart && i == 3) begin
                bus.start = 1'b1;
                bus.limit = W'(3);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check($sformatf("L%0d after busy", L), 32'(bus.busy), 32'd0);
        check($sformatf("L%0d after done", L), 32'(bus.done), 32'd0);
        check($sformatf("L%0d after cnt",  L), 32'(bus.cnt),  32'd0);
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.limit = '0;
        bus.dwell = '0;
        repeat (3) @(negedge clk);
        check("rst en",   32'(bus.en),   32'd0);
        check("rst down", 32'(bus.down), 32'd0);
        check("rst clr",  32'(bus.clr),  32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        res = 1'b1;
        @(negedge clk);
        check("post rst busy", 32'(bus.busy), 32'd0);

        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        @(negedge clk);
        check("idle stop busy", 32'(bus.busy), 32'd0);

        run(5, 2, 2, 1'b0, 1'b0);
        run(3, 1, 1, 1'b0, 1'b0);
        run(0, 3, 1, 1'b0, 1'b0);
        run(15, 0, 1, 1'b0, 1'b0);
        run(6, 1, 1, 1'b0, 1'b1);
        run(4, 0, 2, 1'b1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            run(int'($urandom_range(1, 15)), int'($urandom_range(0, 4)), int'($urandom_range(1, 2)), 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of the falling half of a sweep.
        bus.start = 1'b1;
        bus.limit = W'(6);
        bus.dwell = DW'(1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid down en",   32'(bus.en),   32'd1);
        check("mid down down", 32'(bus.down), 32'd1);
        check("mid down cnt",  32'(bus.cnt),  32'd5);
        #5 res = 1'b0;
        #1;
        check("async en",   32'(bus.en),   32'd0);
        check("async down", 32'(bus.down), 32'd0);
        check("async clr",  32'(bus.clr),  32'd0);
        check("async busy", 32'(bus.busy), 32'd0);
        check("async done", 32'(bus.done), 32'd0);
        @(negedge clk);
        res = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.stop = k[0];
            @(negedge clk);
            check($sformatf("post async %0d busy", k), 32'(bus.busy), 32'd0);
            check($sformatf("post async %0d en", k),   32'(bus.en),   32'd0);
            check($sformatf("post async %0d cnt", k),  32'(bus.cnt),  32'd5);
        end
        bus.stop = 1'b0;

        run(2, 3, 1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/up_down_sweep_ctrl.md
# up_down_sweep_ctrl

Sequencer for the team's up/down counter. It drives the counter's `en`, `down` and `clr` inputs so the counter sweeps from 0 up to a programmable limit, holds, sweeps back down to 0, holds, and repeats until stopped. It observes the counter value and never changes direction while the counter is enabled. It sits between the control logic (start/stop) and one up/down counter instance.

## Interface
Parameters:
- `W`, 4: counter width; `limit` and `cnt` are W bits.
- `DW`, 8: width of the dwell-time input.

Ports:
- `clk`  in  1  system clock, rising edge.
- `res`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request to begin sweeping; ignored while `busy`=1.
- `stop`  in  1  single-cycle request to end after the current full sweep; latched.
- `limit`  in  W  top of sweep; sampled into `lim_q` on an accepted `start`.
- `dwell`  in  DW  hold cycles at each end; sampled into `dwl_q` on an accepted `start`.
- `cnt`  in  W  current value of the controlled counter.
- `en`  out  1  counter enable (registered).
- `down`  out  1  counter direction, 1 = decrement (registered).
- `clr`  out  1  synchronous counter clear (registered).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when returning to IDLE.

## Operation
- Counter contract: on the rising edge, `clr` sets cnt to 0; otherwise `en` sets cnt to cnt-1 if `down`=1, else cnt+1.
- Reset: state=IDLE; `en`=0, `down`=0, `clr`=0, `busy`=0, `done`=0; `stop_q`=0, `lim_q`=0, `dwl_q`=0, dwell timer=0.
- States and transitions:
  - IDLE: outputs quiet. `start` → CLEAR; sample `limit` and `dwell`; clear `stop_q`.
  - CLEAR: `clr`=1 for exactly 1 cycle. Next state is UP, or IDLE with `done` if `lim_q`=0.
  - UP: `en`=1, `down`=0. On the edge where cnt==`lim_q`-1 → DWELL_HI, with `en`=0 from that edge on.
  - DWELL_HI: `en`=0. Stay max(`dwl_q`,1) cycles. `down` goes to 1 in the first dwell cycle. → DOWN.
  - DOWN: `en`=1, `down`=1. On the edge where cnt==1 → DWELL_LO, with `en`=0.
  - DWELL_LO: `en`=0. Stay max(`dwl_q`,1) cycles. `down` goes to 0 in the first cycle. → IDLE with `done` if `stop_q`, else → UP.
- `stop` is latched into `stop_q` in any non-IDLE state and acts only at the end of DWELL_LO. `stop` in IDLE is ignored.
- `start` while `busy` is ignored. `start` and `stop` in the same IDLE cycle: start is accepted and stop is dropped.
- Direction invariant: `down` changes only in cycles where `en`=0.
- `lim_q`=2^W-1 is legal. Comparisons are W-bit; no wrap-around occurs by construction.

## Timing
- `start` sampled at edge N: CLEAR (`clr`=1) during cycle N+1; first `en`=1 at N+2.
- A rising sweep to L takes L enabled cycles. Total period = 2L + 2·max(dwl_q,1) cycles.
- `done` is asserted in the same cycle as the first IDLE cycle; `busy` is low that cycle.
- Asynchronous reset mid-sweep: all outputs go low immediately; the counter value is left to its own reset.

## Structure
- A shared package holds the state encoding (IDLE, CLEAR, UP, DWELL_HI, DOWN, DWELL_LO, 3-bit localparams) and the default `W`/`DW`.
- Sub-module `dwell_timer`: loadable down-counter with a `load`/`expire` interface, instantiated once.
- The bench instantiates this block plus the existing up/down counter. Clock is 50 ns (toggle every 25 ns).

## Test plan
- Reset held low, then released; `start`=1 for one cycle with limit=5, dwell=2 → cnt follows 0,1..5 (hold 2),4..0 (hold 2),1..; `busy`=1; `done`=0.
- `stop` pulsed during the first UP phase → sweep completes; IDLE at cnt=0 after the DWELL_LO that follows; `done` pulses once.
- limit=0 → exactly one `clr` cycle, then `done`; `en` never asserts.
- limit=15 (W=4), dwell=0 → cnt reaches 15 with no overflow; each dwell lasts 1 cycle; the checker confirms `down` never toggles while `en`=1.
- `start` re-pulsed while `busy`, with limit changed to 3 → ignored; the sweep continues to the original limit.
- `res` driven low mid-DOWN → `en`/`down`/`clr`/`busy`=0 immediately; after release, block stays in IDLE until `start`.
